// File: rtl/line_deserializer.sv
// Cache-fill word-to-line deserializer; optional in_last checking under LINE_DESER_LAST_CHECK_EN.
// Latency: line_valid rises 1 cycle after the last word handshake, with a one-cycle bubble between lines.
// Backpressure: in_ready drops while a full line is held; the line stays stable until line_ready.
module line_deserializer #(
  parameter int WORD_W         = 32,
  parameter int WORDS_PER_LINE = 8,
  localparam int LINE_W        = WORD_W * WORDS_PER_LINE,
  localparam int CNT_W         = $clog2(WORDS_PER_LINE)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              line_valid,
  output logic [LINE_W-1:0] line_data,
  input  logic              line_ready,
  output logic [CNT_W-1:0]  word_cnt
`ifdef LINE_DESER_LAST_CHECK_EN
  ,
  input  logic              in_last,
  output logic              err_last
`endif
);

  typedef enum logic {FILL, FULL} state_t;

  state_t state, state_nxt;
  logic   word_acc;
  logic   last_word;

  assign in_ready   = (state == FILL);
  assign line_valid = (state == FULL);
  assign word_acc   = in_valid && in_ready;
  assign last_word  = (word_cnt == CNT_W'(WORDS_PER_LINE - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = FILL;
    end else begin
      case (state)
        FILL: if (word_acc && last_word) state_nxt = FULL;
        FULL: if (line_ready)            state_nxt = FILL;
      endcase
    end
  end

  // Count wraps to 0 on the last word since WORDS_PER_LINE is a power of 2.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)        word_cnt <= '0;
    else if (flush)    word_cnt <= '0;
    else if (word_acc) word_cnt <= word_cnt + CNT_W'(1);
  end

  // A word arriving with flush is dropped; stale slots are otherwise left in place.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      line_data <= '0;
    else if (word_acc && !flush)
      line_data[word_cnt*WORD_W +: WORD_W] <= in_data;
  end

`ifdef LINE_DESER_LAST_CHECK_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      err_last <= 1'b0;
    else if (flush)
      err_last <= 1'b0;
    else if (word_acc && (in_last != last_word))
      err_last <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_line_deserializer.sv
// Directed bench for line_deserializer: inputs driven and outputs sampled on the falling edge.
module tb_line_deserializer;

  logic         CLK;
  logic         RST_N;
  logic         flush;
  logic         in_valid;
  logic [31:0]  in_data;
  logic         in_ready;
  logic         line_valid;
  logic [255:0] line_data;
  logic         line_ready;
  logic [2:0]   word_cnt;
`ifdef LINE_DESER_LAST_CHECK_EN
  logic         in_last;
  logic         err_last;
`endif

  logic [255:0] exp_line;
  int total = 0;
  int bad   = 0;

  line_deserializer dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .line_valid (line_valid),
    .line_data  (line_data),
    .line_ready (line_ready),
    .word_cnt   (word_cnt)
`ifdef LINE_DESER_LAST_CHECK_EN
    ,
    .in_last    (in_last),
    .err_last   (err_last)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
`ifdef LINE_DESER_LAST_CHECK_EN
    in_last  = last;
`else
    if (last) in_valid = 1'b1;
`endif
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  initial begin
    RST_N      = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    line_ready = 1'b0;
    exp_line   = '0;
`ifdef LINE_DESER_LAST_CHECK_EN
    in_last    = 1'b0;
`endif
    #12 RST_N = 1'b1;
    @(negedge CLK);

    // Reset state
    check("rst_in_ready",   in_ready,   1);
    check("rst_line_valid", line_valid, 0);
    check("rst_word_cnt",   word_cnt,   0);
    check("rst_line_data",  line_data,  0);

    // Back-to-back line with line_ready already high
    line_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t1_cnt", word_cnt, i);
      check("t1_lv_low", line_valid, 0);
      send_word(32'h88888888 - i * 32'h11111111, i == 7);
    end
    check("t1_line_valid", line_valid, 1);
    check("t1_in_ready",   in_ready,   0);
    check("t1_cnt_wrap",   word_cnt,   0);
    check("t1_line_data",  line_data,
          256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888);
    @(negedge CLK);
    check("t1_lv_drop",    line_valid, 0);
    check("t1_in_ready_back", in_ready, 1);
    check("t1_data_kept",  line_data,
          256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888);

    // Held line under backpressure, source holding a word
    line_ready = 1'b0;
    for (int j = 0; j < 8; j++) begin
      send_word(32'hA0000000 + j, j == 7);
      exp_line[j*32 +: 32] = 32'hA0000000 + j;
    end
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
`ifdef LINE_DESER_LAST_CHECK_EN
    in_last  = 1'b0;
`endif
    repeat (5) begin
      @(negedge CLK);
      check("t2_in_ready_low", in_ready,   0);
      check("t2_lv_held",      line_valid, 1);
    end
    check("t2_data_stable", line_data, exp_line);
    check("t2_cnt",         word_cnt,  0);
    line_ready = 1'b1;
    @(negedge CLK);
    line_ready = 1'b0;
    check("t2_lv_released", line_valid, 0);
    check("t2_no_accept",   word_cnt,   0);
    @(negedge CLK);
    in_valid = 1'b0;
    check("t2_cnt_after",   word_cnt,   1);
    check("t2_first_word",  line_data[31:0], 32'hDEADBEEF);

    // Flush mid-line with a word offered in the same cycle
    send_word(32'h33330001, 1'b0);
    send_word(32'h33330002, 1'b0);
    check("t3_cnt3", word_cnt, 3);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h55555555;
    @(negedge CLK);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("t3_cnt_flushed", word_cnt,   0);
    check("t3_lv",          line_valid, 0);
    check("t3_word_dropped", line_data[127:96], 32'hA0000003);
    for (int j = 0; j < 8; j++) begin
      send_word(32'hC0000000 + j, j == 7);
      exp_line[j*32 +: 32] = 32'hC0000000 + j;
    end
    check("t3_lv_full", line_valid, 1);
    check("t3_line",    line_data,  exp_line);

    // Flush while holding a full line, even with line_ready high
    flush      = 1'b1;
    line_ready = 1'b1;
    @(negedge CLK);
    flush      = 1'b0;
    line_ready = 1'b0;
    check("t4_lv",       line_valid, 0);
    check("t4_in_ready", in_ready,   1);
    check("t4_cnt",      word_cnt,   0);
    send_word(32'h0F0F0F0F, 1'b0);
    check("t4_restart_cnt", word_cnt, 1);

    // Asynchronous reset mid-line, between clock edges
    for (int j = 1; j < 5; j++) send_word(32'hB0000000 + j, 1'b0);
    check("t5_cnt5",  word_cnt, 5);
    check("t5_word4", line_data[159:128], 32'hB0000004);
    #2 RST_N = 1'b0;
    #1;
    check("t5_async_lv",   line_valid, 0);
    check("t5_async_cnt",  word_cnt,   0);
    check("t5_async_data", line_data,  0);
    check("t5_async_rdy",  in_ready,   1);
    #1 RST_N = 1'b1;
    @(negedge CLK);

`ifdef LINE_DESER_LAST_CHECK_EN
    // Misplaced in_last raises a sticky error without disturbing the line
    check("t6_err_rst", err_last, 0);
    for (int j = 0; j < 8; j++) begin
      send_word(32'hE0000000 + j, (j == 3) || (j == 7));
      if (j == 2) check("t6_err_clean", err_last, 0);
      if (j == 3) check("t6_err_set",   err_last, 1);
    end
    check("t6_err_sticky", err_last,   1);
    check("t6_lv",         line_valid, 1);
    check("t6_word3",      line_data[127:96], 32'hE0000003);
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    check("t6_err_flushed", err_last,   0);
    check("t6_lv_flushed",  line_valid, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
